core_tracked: RTL and testbench

Parametrised traffic-generating core for the coherency experiments. It issues read and write requests to the shared memory/arbiter under a hold-until-accepted handshake, and stamps every written word with its core id and a per-address sequence number. It tracks in-order read returns against its own last write to each address and flags stale reads. One instance sits per core in front of the arbiter; the sticky error outputs are observed by the bench.

---
 rtl/core_tracked.sv | 180 ++++++++++++++++++
 tb/tb_core_tracked.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_tracked.sv
`default_nettype none
// ============================================================================
// Module   : core_tracked
// Brief    : Coherency traffic core. Issues hold-until-accepted read/write
//            requests, stamps written words with {ID, per-address sequence},
//            and checks in-order read returns against its own last write.
// Revision : 1.0  initial release
// ============================================================================
module core_tracked #(
  parameter int ID        = 0,
  parameter int ID_W      = 4,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_rd,
  input  logic                         i_wr,
  input  logic [ADDR_W-1:0]            i_addr,
  output logic                         rd,
  output logic                         wr,
  output logic [ADDR_W-1:0]            addr,
  output logic [DATA_W-1:0]            wdata,
  input  logic                         rdy,
  input  logic                         rvalid,
  input  logic [DATA_W-1:0]            rdata,
  output logic                         stall,
  output logic [$clog2(OUT_DEPTH):0]   outstanding,
  output logic                         err_stale,
  output logic                         err_unexp,
  output logic [7:0]                   err_cnt
);

  localparam int c_seq_w  = DATA_W - ID_W;
  localparam int c_ptr_w  = $clog2(OUT_DEPTH);
  localparam int c_cnt_w  = c_ptr_w + 1;
  localparam int c_n_addr = 2 ** ADDR_W;
  localparam logic [ID_W-1:0]    c_id   = ID_W'(ID);
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(OUT_DEPTH);

  // Request register
  logic                r_rd;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  // Per-address shadow of our own writes
  logic [c_seq_w-1:0]  r_seq [c_n_addr];
  logic [c_n_addr-1:0] r_vld;

  // Expected-return FIFO: each entry is {valid, seq} snapshot at read load
  logic [c_seq_w:0]    r_fifo [OUT_DEPTH];
  logic [c_ptr_w-1:0]  r_wptr;
  logic [c_ptr_w-1:0]  r_rptr;
  logic [c_cnt_w-1:0]  r_count;

  logic                r_err_stale;
  logic                r_err_unexp;
  logic [7:0]          r_err_cnt;

  logic                w_free;
  logic                w_full;
  logic                w_load_wr;
  logic                w_load_rd;
  logic                w_pop;
  logic [c_seq_w-1:0]  w_seq_next;
  logic [c_seq_w:0]    w_head;
  logic                w_stale;

  // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot
  assign w_free     = !(r_rd || r_wr) || rdy;
  assign w_full     = (r_count == c_full);
  assign w_load_wr  = w_free && i_wr;
  assign w_load_rd  = w_free && !i_wr && i_rd && !w_full;
  assign w_pop      = rvalid && (r_count != '0);
  assign w_seq_next = r_seq[i_addr] + c_seq_w'(1);
  assign w_head     = r_fifo[r_rptr];
  // Only own-id data returned for an address we have written is checked
  assign w_stale    = w_pop && w_head[c_seq_w]
                      && (rdata[DATA_W-1 -: ID_W] == c_id)
                      && (rdata[c_seq_w-1:0] != w_head[c_seq_w-1:0]);

  assign stall = (i_rd || i_wr) && (!w_free || (!i_wr && i_rd && w_full));

  assign rd          = r_rd;
  assign wr          = r_wr;
  assign addr        = r_addr;
  assign wdata       = r_wdata;
  assign outstanding = r_count;
  assign err_stale   = r_err_stale;
  assign err_unexp   = r_err_unexp;
  assign err_cnt     = r_err_cnt;

  // Request register: load a new request whenever the previous one is gone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_free) begin
      if (w_load_wr) begin
        r_wr    <= 1'b1;
        r_rd    <= 1'b0;
        r_addr  <= i_addr;
        r_wdata <= {c_id, w_seq_next};
      end else if (w_load_rd) begin
        r_wr    <= 1'b0;
        r_rd    <= 1'b1;
        r_addr  <= i_addr;
      end else begin
        r_wr    <= 1'b0;
        r_rd    <= 1'b0;
      end
    end
  end

  // Shadow sequence numbers advance on every write load; wrap is silent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_n_addr; i++) begin
        r_seq[i] <= '0;
      end
      r_vld <= '0;
    end else if (w_load_wr) begin
      r_seq[i_addr] <= w_seq_next;
      r_vld[i_addr] <= 1'b1;
    end
  end

  // FIFO storage: snapshot of the shadow entry taken when a read loads
  always_ff @(posedge clk) begin
    if (w_load_rd) begin
      r_fifo[r_wptr] <= {r_vld[i_addr], r_seq[i_addr]};
    end
  end

  // FIFO pointers and occupancy; push and pop on one edge cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_load_rd) begin
        r_wptr <= r_wptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_w'(1);
      end
      if (w_load_rd && !w_pop) begin
        r_count <= r_count + c_cnt_w'(1);
      end else if (!w_load_rd && w_pop) begin
        r_count <= r_count - c_cnt_w'(1);
      end
    end
  end

  // Sticky error flags and saturating stale counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_stale <= 1'b0;
      r_err_unexp <= 1'b0;
      r_err_cnt   <= 8'd0;
    end else begin
      if (w_stale) begin
        r_err_stale <= 1'b1;
        if (r_err_cnt != 8'hFF) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end
      if (rvalid && (r_count == '0)) begin
        r_err_unexp <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_tracked.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_tracked
// Brief    : Self-checking bench for core_tracked (ID=3, 8-bit data, 4 addrs,
//            4 outstanding reads). Directed scenarios then random traffic,
//            all compared against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_core_tracked;

  localparam int c_id = 3;

  logic       clk;
  logic       rst_n;
  logic       i_rd;
  logic       i_wr;
  logic [1:0] i_addr;
  logic       rd;
  logic       wr;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       rdy;
  logic       rvalid;
  logic [7:0] rdata;
  logic       stall;
  logic [2:0] outstanding;
  logic       err_stale;
  logic       err_unexp;
  logic [7:0] err_cnt;

  int total;
  int bad;

  // Reference model state
  logic       m_rd;
  logic       m_wr;
  logic [1:0] m_addr;
  logic [7:0] m_wdata;
  int         m_seq [4];
  bit         m_vld [4];
  logic [4:0] m_q [$];
  bit         m_stale;
  bit         m_unexp;
  int         m_cnt;

  core_tracked #(
    .ID(c_id), .ID_W(4), .DATA_W(8), .ADDR_W(2), .OUT_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr),
    .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdy(rdy),
    .rvalid(rvalid), .rdata(rdata), .stall(stall), .outstanding(outstanding),
    .err_stale(err_stale), .err_unexp(err_unexp), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rd = 0; m_wr = 0; m_addr = 0; m_wdata = 0;
    for (int i = 0; i < 4; i++) begin
      m_seq[i] = 0;
      m_vld[i] = 0;
    end
    m_q.delete();
    m_stale = 0; m_unexp = 0; m_cnt = 0;
  endtask

  function automatic logic model_stall();
    bit free;
    bit full;
    free = !(m_rd || m_wr) || rdy;
    full = (m_q.size() == 4);
    return (i_rd || i_wr) && (!free || (!i_wr && i_rd && full));
  endfunction

  // One clock edge of the core as described by its rules
  task automatic model_edge();
    bit free;
    bit full;
    logic [4:0] e;
    free = !(m_rd || m_wr) || rdy;
    full = (m_q.size() == 4);
    if (rvalid) begin
      if (m_q.size() > 0) begin
        e = m_q.pop_front();
        if (e[4] && rdata[7:4] == c_id && rdata[3:0] != e[3:0]) begin
          m_stale = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end else begin
        m_unexp = 1;
      end
    end
    if (free) begin
      if (i_wr) begin
        m_seq[i_addr] = (m_seq[i_addr] + 1) % 16;
        m_vld[i_addr] = 1;
        m_wr = 1; m_rd = 0; m_addr = i_addr;
        m_wdata = 8'(c_id * 16 + m_seq[i_addr]);
      end else if (i_rd && !full) begin
        m_q.push_back({m_vld[i_addr], 4'(m_seq[i_addr])});
        m_rd = 1; m_wr = 0; m_addr = i_addr;
      end else begin
        m_rd = 0; m_wr = 0;
      end
    end
  endtask

  task automatic check_outs();
    chk("rd", rd, m_rd);
    chk("wr", wr, m_wr);
    chk("addr", addr, m_addr);
    chk("wdata", wdata, m_wdata);
    chk("outstanding", outstanding, m_q.size());
    chk("err_stale", err_stale, m_stale);
    chk("err_unexp", err_unexp, m_unexp);
    chk("err_cnt", err_cnt, m_cnt);
  endtask

  // Entered at posedge+1; drives inputs, checks stall, clocks, checks outputs
  task automatic cyc(input logic w, input logic r, input logic [1:0] a,
                     input logic ry, input logic rv, input logic [7:0] rdd);
    i_wr = w; i_rd = r; i_addr = a; rdy = ry; rvalid = rv; rdata = rdd;
    #2;
    chk("stall", stall, model_stall());
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  initial begin
    int sel;
    logic rv;
    logic [7:0] rdd;
    logic [4:0] e;

    total = 0; bad = 0;
    rst_n = 0; i_rd = 0; i_wr = 0; i_addr = 0; rdy = 0; rvalid = 0; rdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    #2 rst_n = 1;
    @(posedge clk); #1;

    // Two writes then a matching read
    cyc(1, 0, 2, 1, 0, 8'h00);
    chk("wdata_first", wdata, 8'h31);
    cyc(1, 0, 2, 1, 0, 8'h00);
    chk("wdata_second", wdata, 8'h32);
    cyc(0, 1, 2, 1, 0, 8'h00);
    chk("outs_after_read", outstanding, 1);
    cyc(0, 0, 0, 1, 1, 8'h32);
    chk("outs_after_ret", outstanding, 0);
    chk("no_stale", err_stale, 0);

    // Stale return, then a foreign-id return
    cyc(0, 1, 2, 1, 0, 8'h00);
    cyc(0, 0, 0, 1, 1, 8'h31);
    chk("stale_flag", err_stale, 1);
    chk("stale_cnt", err_cnt, 1);
    cyc(0, 1, 2, 1, 0, 8'h00);
    cyc(0, 0, 0, 1, 1, 8'h51);
    chk("foreign_cnt", err_cnt, 1);

    // Write held while rdy is low
    cyc(1, 0, 1, 0, 0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 3, 0, 0, 8'h00);
      chk("hold_stall", stall, 1);
      chk("hold_wr", wr, 1);
      chk("hold_wdata", wdata, 8'h31);
      chk("hold_addr", addr, 1);
    end
    cyc(0, 1, 3, 1, 0, 8'h00);
    chk("taken_rd", rd, 1);

    // FIFO full with a same-cycle pop
    cyc(0, 0, 0, 1, 1, 8'h00);
    for (int k = 0; k < 4; k++) cyc(0, 1, 1, 1, 0, 8'h00);
    chk("outs_full", outstanding, 4);
    i_rd = 1; i_wr = 0; i_addr = 1; rdy = 1; rvalid = 1; rdata = 8'h31;
    #2;
    chk("full_stall", stall, 1);
    @(posedge clk); model_edge(); #1; check_outs();
    chk("full_pop", outstanding, 3);
    cyc(0, 1, 1, 1, 0, 8'h00);
    chk("full_accept", outstanding, 4);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 1, 8'h31);
    chk("drain_cnt", err_cnt, 1);

    // Sequence wrap on address 0, then an unexpected return
    for (int k = 0; k < 16; k++) begin
      cyc(1, 0, 0, 1, 0, 8'h00);
      chk("wrap_wdata", wdata, 8'h30 | ((k + 1) & 15));
    end
    cyc(0, 1, 0, 1, 0, 8'h00);
    cyc(0, 0, 0, 1, 1, 8'h30);
    chk("wrap_cnt", err_cnt, 1);
    chk("unexp_before", err_unexp, 0);
    cyc(0, 0, 0, 1, 1, 8'h30);
    chk("unexp_after", err_unexp, 1);

    // Asynchronous reset with reads outstanding
    cyc(0, 1, 2, 1, 0, 8'h00);
    cyc(0, 1, 2, 1, 0, 8'h00);
    chk("outs_two", outstanding, 2);
    i_rd = 0; i_wr = 0; rvalid = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    check_outs();
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
    cyc(0, 0, 0, 1, 1, 8'h32);
    chk("unexp_post_reset", err_unexp, 1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      if (m_q.size() > 0) rv = ($urandom_range(0, 2) == 0);
      else                rv = ($urandom_range(0, 40) == 0);
      rdd = 8'($urandom);
      if (m_q.size() > 0) begin
        e = m_q[0];
        sel = $urandom_range(0, 3);
        if (sel == 0)      rdd = {4'(c_id), e[3:0]};
        else if (sel == 1) rdd = {4'(c_id), 4'(e[3:0] + 4'd1)};
        else if (sel == 2) rdd = {4'(c_id + 1 + $urandom_range(0, 11)), 4'($urandom)};
      end
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
          2'($urandom), ($urandom_range(0, 3) != 0), rv, rdd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
